// File: rtl/gin_pkg.sv
// Shared definitions for the row multicast bus sequencer: controller states
// and the field layout of the {enable, tag, value} bus word.
package gin_pkg;

  localparam int GIN_ID_LEN    = 5;
  localparam int GIN_VALUE_LEN = 32;

  // Bus word layout, LSB first: value, then tag, then the enable bit on top.
  localparam int GIN_VALUE_LSB = 0;
  localparam int GIN_TAG_LSB   = GIN_VALUE_LEN;
  localparam int GIN_EN_BIT    = GIN_VALUE_LEN + GIN_ID_LEN;
  localparam int GIN_BUS_W     = GIN_EN_BIT + 1;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } gin_state_e;

endpackage

// File: rtl/gin_issue_slot.sv
// Single-entry valid/ready register that holds the value currently offered
// on the multicast bus.
module gin_issue_slot
  import gin_pkg::*;
#(
  parameter int ID_LEN    = GIN_ID_LEN,
  parameter int VALUE_LEN = GIN_VALUE_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic [ID_LEN-1:0]           i_tag,
  input  logic [VALUE_LEN-1:0]        i_value,
  input  logic                        i_bus_ready,
  output logic                        o_valid,
  output logic                        o_xfer,
  output logic [VALUE_LEN+ID_LEN:0]   o_bus_word
);

  logic                 r_valid;
  logic [ID_LEN-1:0]    r_tag;
  logic [VALUE_LEN-1:0] r_value;

  // A load takes priority over a drain so that a simultaneous transfer and
  // accept replaces the entry without a bubble. An emptied slot is zeroed so
  // the bus never shows stale tag/value bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_value <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_value <= i_value;
    end else if (r_valid && i_bus_ready) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_value <= '0;
    end
  end

  assign o_valid    = r_valid;
  assign o_xfer     = r_valid && i_bus_ready;
  assign o_bus_word = {r_valid, r_tag, r_value};

endmodule

// File: rtl/gin_bus_sequencer.sv
// Owns one row multicast bus: shifts MASTER_NUMS PE IDs into the scan chain,
// then issues tagged values onto the bus through a single registered slot.
module gin_bus_sequencer
  import gin_pkg::*;
#(
  parameter int MASTER_NUMS = 14,
  parameter int ID_LEN      = GIN_ID_LEN,
  parameter int VALUE_LEN   = GIN_VALUE_LEN,
  parameter int CNT_LEN     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cfg_start,
  input  logic                        i_cfg_id_valid,
  output logic                        o_cfg_id_ready,
  input  logic [ID_LEN-1:0]           i_cfg_id,
  output logic                        o_cfg_done,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [ID_LEN-1:0]           i_in_tag,
  input  logic [VALUE_LEN-1:0]        i_in_value,
  output logic [VALUE_LEN+ID_LEN:0]   o_bus_enable_tag_value,
  input  logic                        i_bus_ready,
  output logic                        o_set_id,
  output logic [ID_LEN-1:0]           o_id_scan_in,
  output logic                        o_configured,
  output logic [CNT_LEN-1:0]          o_xfer_count
);

  localparam int                LCNT_W   = $clog2(MASTER_NUMS + 1);
  localparam logic [LCNT_W-1:0] LOAD_MAX = LCNT_W'(MASTER_NUMS);
  localparam logic [LCNT_W-1:0] LAST_IDX = LCNT_W'(MASTER_NUMS - 1);

  gin_state_e          r_state;
  logic [LCNT_W-1:0]   r_load_cnt;
  logic                r_set_id;
  logic [ID_LEN-1:0]   r_id_scan_in;
  logic                r_cfg_done;
  logic [CNT_LEN-1:0]  r_xfer_count;

  logic                w_slot_v;
  logic                w_xfer;
  logic                w_accept;
  logic                w_id_accept;

  assign o_cfg_id_ready = (r_state == LOAD) && (r_load_cnt < LOAD_MAX);
  assign w_id_accept    = o_cfg_id_ready && i_cfg_id_valid;

  // Only RUN may refill the slot; DRAIN lets the pending beat leave but
  // holds the upstream stream off while the chain is about to be reloaded.
  assign o_in_ready = (r_state == RUN) && (!w_slot_v || i_bus_ready);
  assign w_accept   = i_in_valid && o_in_ready;

  gin_issue_slot #(
    .ID_LEN    (ID_LEN),
    .VALUE_LEN (VALUE_LEN)
  ) u_slot (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_tag       (i_in_tag),
    .i_value     (i_in_value),
    .i_bus_ready (i_bus_ready),
    .o_valid     (w_slot_v),
    .o_xfer      (w_xfer),
    .o_bus_word  (o_bus_enable_tag_value)
  );

  // Controller FSM with the registered scan-chain drive. cfg_done is raised
  // on the same edge as the final shift so it lines up with the last set_id.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= UNCFG;
      r_load_cnt   <= '0;
      r_set_id     <= 1'b0;
      r_id_scan_in <= '0;
      r_cfg_done   <= 1'b0;
    end else begin
      r_set_id     <= w_id_accept;
      r_id_scan_in <= w_id_accept ? i_cfg_id : '0;
      r_cfg_done   <= w_id_accept && (r_load_cnt == LAST_IDX);

      case (r_state)
        UNCFG: begin
          if (i_cfg_start) begin
            r_state    <= LOAD;
            r_load_cnt <= '0;
          end
        end
        LOAD: begin
          if (w_id_accept) begin
            r_load_cnt <= r_load_cnt + 1'b1;
            if (r_load_cnt == LAST_IDX) begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          // An accept on the same cycle as cfg_start still lands in the slot,
          // so it too must be drained before reloading.
          if (i_cfg_start) begin
            if (w_slot_v || w_accept) begin
              r_state <= DRAIN;
            end else begin
              r_state    <= LOAD;
              r_load_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (!w_slot_v || i_bus_ready) begin
            r_state    <= LOAD;
            r_load_cnt <= '0;
          end
        end
        default: begin
          r_state <= UNCFG;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_count <= '0;
    end else if (w_xfer) begin
      r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  assign o_set_id     = r_set_id;
  assign o_id_scan_in = r_id_scan_in;
  assign o_cfg_done   = r_cfg_done;
  assign o_configured = (r_state == RUN);
  assign o_xfer_count = r_xfer_count;

endmodule

// File: tb/tb_gin_bus_sequencer.sv
// Self-checking bench for gin_bus_sequencer: directed load/stream sequences,
// a hand-computed vector table and randomized traffic against a queue model.
module tb_gin_bus_sequencer;
  import gin_pkg::*;

  localparam int MN  = 14;
  localparam int IDL = 5;
  localparam int VL  = 32;
  localparam int CL  = 16;

  localparam int M_UNCFG = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  typedef struct {
    logic           rst;
    logic           cfgStart;
    logic           idValid;
    logic [IDL-1:0] id;
    logic           inValid;
    logic [IDL-1:0] tag;
    logic [VL-1:0]  value;
    logic           busReady;
  } stim_t;

  typedef struct {
    stim_t          s;
    logic           expInReady;
    logic           expEn;
    logic [IDL-1:0] expTag;
    logic [VL-1:0]  expValue;
    logic [CL-1:0]  expXfer;
    logic           expConfigured;
    logic           expIdReady;
  } vec_t;

  typedef struct {
    logic [IDL-1:0] tag;
    logic [VL-1:0]  value;
  } beat_t;

  logic           clk;
  logic           rst;
  logic           cfgStart;
  logic           cfgIdValid;
  logic           cfgIdReady;
  logic [IDL-1:0] cfgId;
  logic           cfgDone;
  logic           inValid;
  logic           inReady;
  logic [IDL-1:0] inTag;
  logic [VL-1:0]  inValue;
  logic [VL+IDL:0] busWord;
  logic           busReady;
  logic           setId;
  logic [IDL-1:0] idScanIn;
  logic           configured;
  logic [CL-1:0]  xferCount;

  int vectors     = 0;
  int miscompares = 0;

  int    mMode   = M_UNCFG;
  int    mLoaded = 0;
  int    mXfers  = 0;
  beat_t mSlot[$];
  logic  mSetId  = 1'b0;
  logic [IDL-1:0] mScan = '0;
  logic  mDone   = 1'b0;

  int obsSetId  = 0;
  int obsDone   = 0;
  int setIdRun  = 0;
  int maxSetRun = 0;

  vec_t table_q[$];

  gin_bus_sequencer #(
    .MASTER_NUMS (MN),
    .ID_LEN      (IDL),
    .VALUE_LEN   (VL),
    .CNT_LEN     (CL)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_cfg_start            (cfgStart),
    .i_cfg_id_valid         (cfgIdValid),
    .o_cfg_id_ready         (cfgIdReady),
    .i_cfg_id               (cfgId),
    .o_cfg_done             (cfgDone),
    .i_in_valid             (inValid),
    .o_in_ready             (inReady),
    .i_in_tag               (inTag),
    .i_in_value             (inValue),
    .o_bus_enable_tag_value (busWord),
    .i_bus_ready            (busReady),
    .o_set_id               (setId),
    .o_id_scan_in           (idScanIn),
    .o_configured           (configured),
    .o_xfer_count           (xferCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim(input logic r, input logic st, input logic iv,
                                   input logic [IDL-1:0] id, input logic dv,
                                   input logic [IDL-1:0] tg, input logic [VL-1:0] val,
                                   input logic br);
    stim_t s;
    s.rst = r; s.cfgStart = st; s.idValid = iv; s.id = id;
    s.inValid = dv; s.tag = tg; s.value = val; s.busReady = br;
    return s;
  endfunction

  function automatic vec_t mkRow(input logic dv, input logic [IDL-1:0] tg,
                                 input logic [VL-1:0] val, input logic br, input logic st,
                                 input logic eRdy, input logic eEn, input logic [IDL-1:0] eTag,
                                 input logic [VL-1:0] eVal, input logic [CL-1:0] eX,
                                 input logic eCfg, input logic eIdR);
    vec_t v;
    v.s = mkStim(1'b0, st, 1'b0, '0, dv, tg, val, br);
    v.expInReady = eRdy; v.expEn = eEn; v.expTag = eTag; v.expValue = eVal;
    v.expXfer = eX; v.expConfigured = eCfg; v.expIdReady = eIdR;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot behaviour of the bus as seen from the outside: it may take a new
  // beat when empty or when its current beat leaves this cycle.
  function automatic logic modelInReady(input logic br);
    return (mMode == M_RUN) && ((mSlot.size() == 0) || br);
  endfunction

  task automatic modelEdge(input stim_t s);
    logic idAcc, inAcc, xfer, hadSlot;
    beat_t b;
    if (s.rst) begin
      mMode = M_UNCFG; mLoaded = 0; mXfers = 0; mSlot.delete();
      mSetId = 1'b0; mScan = '0; mDone = 1'b0;
      return;
    end
    hadSlot = (mSlot.size() != 0);
    idAcc   = (mMode == M_LOAD) && s.idValid;
    inAcc   = s.inValid && modelInReady(s.busReady);
    xfer    = hadSlot && s.busReady;
    mSetId  = idAcc;
    mScan   = idAcc ? s.id : '0;
    mDone   = idAcc && (mLoaded == MN - 1);
    if (xfer) begin
      mXfers++;
      b = mSlot.pop_front();
    end
    if (inAcc) begin
      b.tag = s.tag; b.value = s.value;
      mSlot.push_back(b);
    end
    case (mMode)
      M_UNCFG: if (s.cfgStart) begin mMode = M_LOAD; mLoaded = 0; end
      M_LOAD:  if (idAcc) begin
                 mLoaded++;
                 if (mLoaded == MN) mMode = M_RUN;
               end
      M_RUN:   if (s.cfgStart) begin
                 if (hadSlot || inAcc) mMode = M_DRAIN;
                 else begin mMode = M_LOAD; mLoaded = 0; end
               end
      default: if (!hadSlot || s.busReady) begin mMode = M_LOAD; mLoaded = 0; end
    endcase
  endtask

  task automatic applyStimulus(input stim_t s);
    rst = s.rst; cfgStart = s.cfgStart; cfgIdValid = s.idValid; cfgId = s.id;
    inValid = s.inValid; inTag = s.tag; inValue = s.value; busReady = s.busReady;
    #1;
  endtask

  task automatic checkOutput(input stim_t s);
    logic [VL+IDL:0] expBus;
    expBus = '0;
    if (mSlot.size() != 0) expBus = {1'b1, mSlot[0].tag, mSlot[0].value};
    checkVal("cfg_id_ready", 64'(cfgIdReady), 64'(mMode == M_LOAD));
    checkVal("in_ready",     64'(inReady),    64'(modelInReady(s.busReady)));
    checkVal("bus_word",     64'(busWord),    64'(expBus));
    checkVal("set_id",       64'(setId),      64'(mSetId));
    checkVal("id_scan_in",   64'(idScanIn),   64'(mScan));
    checkVal("cfg_done",     64'(cfgDone),    64'(mDone));
    checkVal("configured",   64'(configured), 64'(mMode == M_RUN));
    checkVal("xfer_count",   64'(xferCount),  64'(mXfers[CL-1:0]));
  endtask

  task automatic doCycle(input stim_t s);
    applyStimulus(s);
    checkOutput(s);
    if (setId === 1'b1) begin
      obsSetId++; setIdRun++;
      if (setIdRun > maxSetRun) maxSetRun = setIdRun;
    end else begin
      setIdRun = 0;
    end
    if (cfgDone === 1'b1) obsDone++;
    @(posedge clk);
    modelEdge(s);
    #1;
  endtask

  task automatic clearObs();
    obsSetId = 0; obsDone = 0; setIdRun = 0; maxSetRun = 0;
  endtask

  task automatic checkResetValues(input string pfx);
    checkVal({pfx, "_set_id"},       64'(setId),      64'd0);
    checkVal({pfx, "_id_scan_in"},   64'(idScanIn),   64'd0);
    checkVal({pfx, "_cfg_id_ready"}, 64'(cfgIdReady), 64'd0);
    checkVal({pfx, "_cfg_done"},     64'(cfgDone),    64'd0);
    checkVal({pfx, "_in_ready"},     64'(inReady),    64'd0);
    checkVal({pfx, "_bus_word"},     64'(busWord),    64'd0);
    checkVal({pfx, "_configured"},   64'(configured), 64'd0);
    checkVal({pfx, "_xfer_count"},   64'(xferCount),  64'd0);
  endtask

  task automatic fullLoad(input string pfx, input int idBase);
    clearObs();
    doCycle(mkStim(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1));
    for (int i = 0; i < MN; i++)
      doCycle(mkStim(1'b0, 1'b0, 1'b1, IDL'(idBase + i), 1'b0, '0, '0, 1'b1));
    for (int i = 0; i < 2; i++)
      doCycle(mkStim(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1));
    checkVal({pfx, "_set_id_cycles"}, 64'(obsSetId), 64'(MN));
    checkVal({pfx, "_set_id_run"},    64'(maxSetRun), 64'(MN));
    checkVal({pfx, "_cfg_done_pulses"}, 64'(obsDone), 64'd1);
    checkVal({pfx, "_configured"},    64'(configured), 64'd1);
  endtask

  initial begin
    stim_t s;
    vec_t  v;

    // Run-phase table: 8-beat burst, 5-cycle stall, then cfg_start with a
    // pending beat that must drain before LOAD.
    for (int i = 0; i < 8; i++)
      table_q.push_back(mkRow(1'b1, 5'd3, 32'hA0 + i, 1'b1, 1'b0, 1'b1, i > 0,
                              (i > 0) ? 5'd3 : 5'd0, (i > 0) ? 32'hA0 + i - 1 : 32'h0,
                              (i > 0) ? CL'(i - 1) : CL'(0), 1'b1, 1'b0));
    table_q.push_back(mkRow(1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'hA7, 16'd7,  1'b1, 1'b0));
    table_q.push_back(mkRow(1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  16'd8,  1'b1, 1'b0));
    table_q.push_back(mkRow(1'b1, 5'd5, 32'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  16'd8,  1'b1, 1'b0));
    for (int i = 0; i < 5; i++)
      table_q.push_back(mkRow(1'b1, 5'd5, 32'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hB0, 16'd8, 1'b1, 1'b0));
    table_q.push_back(mkRow(1'b1, 5'd5, 32'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hB0, 16'd8,  1'b1, 1'b0));
    table_q.push_back(mkRow(1'b1, 5'd5, 32'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hB1, 16'd9,  1'b1, 1'b0));
    table_q.push_back(mkRow(1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hB2, 16'd10, 1'b1, 1'b0));
    table_q.push_back(mkRow(1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  16'd11, 1'b1, 1'b0));
    table_q.push_back(mkRow(1'b1, 5'd7, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  16'd11, 1'b1, 1'b0));
    table_q.push_back(mkRow(1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hC0, 16'd11, 1'b1, 1'b0));
    table_q.push_back(mkRow(1'b1, 5'd7, 32'hC1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hC0, 16'd11, 1'b0, 1'b0));
    table_q.push_back(mkRow(1'b1, 5'd7, 32'hC1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'hC0, 16'd11, 1'b0, 1'b0));
    table_q.push_back(mkRow(1'b1, 5'd7, 32'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  16'd12, 1'b0, 1'b1));

    s = mkStim(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    applyStimulus(s);
    @(posedge clk);
    modelEdge(s);
    #1;
    doCycle(s);
    checkResetValues("reset");

    fullLoad("load_b2b", 0);

    foreach (table_q[k]) begin
      v = table_q[k];
      applyStimulus(v.s);
      checkOutput(v.s);
      checkVal($sformatf("tbl%0d_in_ready", k),   64'(inReady), 64'(v.expInReady));
      checkVal($sformatf("tbl%0d_enable", k),     64'(busWord[GIN_EN_BIT]), 64'(v.expEn));
      checkVal($sformatf("tbl%0d_tag", k),        64'(busWord[GIN_TAG_LSB +: IDL]), 64'(v.expTag));
      checkVal($sformatf("tbl%0d_value", k),      64'(busWord[GIN_VALUE_LSB +: VL]), 64'(v.expValue));
      checkVal($sformatf("tbl%0d_xfer_count", k), 64'(xferCount), 64'(v.expXfer));
      checkVal($sformatf("tbl%0d_configured", k), 64'(configured), 64'(v.expConfigured));
      checkVal($sformatf("tbl%0d_cfg_id_ready", k), 64'(cfgIdReady), 64'(v.expIdReady));
      @(posedge clk);
      modelEdge(v.s);
      #1;
    end

    // Gapped ID stream: the chain only shifts on accepted IDs.
    clearObs();
    for (int k = 0; k < 2 * MN; k++)
      doCycle(mkStim(1'b0, 1'b0, (k % 2) == 0, IDL'(16 + k / 2), 1'b0, '0, '0, 1'b1));
    for (int i = 0; i < 2; i++)
      doCycle(mkStim(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1));
    checkVal("gap_set_id_cycles", 64'(obsSetId), 64'(MN));
    checkVal("gap_set_id_run",    64'(maxSetRun), 64'd1);
    checkVal("gap_cfg_done",      64'(obsDone), 64'd1);
    checkVal("gap_configured",    64'(configured), 64'd1);

    // Reset arriving together with the 7th ID of a reload.
    doCycle(mkStim(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1));
    for (int i = 0; i < 7; i++)
      doCycle(mkStim(i == 6, 1'b0, 1'b1, IDL'(i), 1'b0, '0, '0, 1'b1));
    doCycle(mkStim(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1));
    checkResetValues("midload_rst");
    fullLoad("reload", 8);

    for (int n = 0; n < 3000; n++) begin
      s.rst      = ($urandom_range(0, 499) == 0);
      s.cfgStart = ($urandom_range(0, 39) == 0);
      s.idValid  = ($urandom_range(0, 1) == 1);
      s.id       = IDL'($urandom);
      s.inValid  = ($urandom_range(0, 9) < 7);
      s.tag      = IDL'($urandom);
      s.value    = $urandom;
      s.busReady = ($urandom_range(0, 9) < 7);
      doCycle(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
